// File: rtl/router_pkg.sv
// Shared port and direction types for the east-edge router input stage.
// Port order sets both the round-robin sequence and the fixed-priority order.
package router_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    PORT_NORTH = 2'd0,
    PORT_SOUTH = 2'd1,
    PORT_WEST  = 2'd2,
    PORT_EAST  = 2'd3
  } port_e;

  typedef enum logic [2:0] {
    MODE_NORTH = 3'd0,
    MODE_SOUTH = 3'd1,
    MODE_WEST  = 3'd2,
    MODE_EAST  = 3'd3,
    MODE_LOCAL = 3'd4
  } router_mode_e;

endpackage

// File: rtl/router_port_fifo.sv
// Per-port word buffer with registered occupancy count.
// A full FIFO refuses a push even if it pops in the same cycle.
module router_port_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally; count moves only on unbalanced push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/router_input_arbiter.sv
// Four-port input buffer and one-hot arbiter ahead of the east-edge router.
// ARB_FIXED_PRIORITY_EN selects fixed N>S>W>E priority instead of round-robin.
module router_input_arbiter
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] north_data_i,
  input  logic                  north_enable_i,
  output logic                  north_ready_o,
  input  logic [DATA_WIDTH-1:0] south_data_i,
  input  logic                  south_enable_i,
  output logic                  south_ready_o,
  input  logic [DATA_WIDTH-1:0] west_data_i,
  input  logic                  west_enable_i,
  output logic                  west_ready_o,
  input  logic [DATA_WIDTH-1:0] east_data_i,
  input  logic                  east_enable_i,
  output logic                  east_ready_o,
  input  logic                  stall_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  north_enable_o,
  output logic                  south_enable_o,
  output logic                  west_enable_o,
  output logic                  east_enable_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] din   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] head  [NUM_PORTS];
  logic [CW-1:0]         count [NUM_PORTS];
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  ready;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  empty;
  logic [1:0]            start;
  logic [1:0]            sel;
  logic                  grant;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_PORTS-1:0]  en_q;

  assign din[PORT_NORTH] = north_data_i;
  assign din[PORT_SOUTH] = south_data_i;
  assign din[PORT_WEST]  = west_data_i;
  assign din[PORT_EAST]  = east_data_i;

  assign req[PORT_NORTH] = north_enable_i;
  assign req[PORT_SOUTH] = south_enable_i;
  assign req[PORT_WEST]  = west_enable_i;
  assign req[PORT_EAST]  = east_enable_i;

  assign north_ready_o = ready[PORT_NORTH];
  assign south_ready_o = ready[PORT_SOUTH];
  assign west_ready_o  = ready[PORT_WEST];
  assign east_ready_o  = ready[PORT_EAST];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign ready[p] = (count[p] < CW'(FIFO_DEPTH));
    assign push[p]  = req[p] & ~full[p];
    assign pop[p]   = grant & (sel == 2'(p));

    router_port_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push[p]),
      .wr_data (din[p]),
      .pop     (pop[p]),
      .head    (head[p]),
      .count   (count[p]),
      .full    (full[p]),
      .empty   (empty[p])
    );
  end

`ifdef ARB_FIXED_PRIORITY_EN
  assign start = 2'(PORT_NORTH);
`else
  port_e rr_ptr;

  assign start = rr_ptr;

  // Next search begins one past the port just granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= PORT_NORTH;
    end else if (grant) begin
      rr_ptr <= port_e'(sel + 2'd1);
    end
  end
`endif

  // Pick the first non-empty port at or after start; stall blocks any grant.
  always_comb begin
    grant = 1'b0;
    sel   = start;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (!empty[start + 2'(i)]) begin
        grant = 1'b1;
        sel   = start + 2'(i);
      end
    end
    if (stall_i) grant = 1'b0;
  end

  // Register the popped head word and its one-hot enable; idle is all zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      en_q   <= '0;
    end else if (grant) begin
      data_q <= head[sel];
      en_q   <= 4'b0001 << sel;
    end else begin
      data_q <= '0;
      en_q   <= '0;
    end
  end

  assign data_o         = data_q;
  assign north_enable_o = en_q[PORT_NORTH];
  assign south_enable_o = en_q[PORT_SOUTH];
  assign west_enable_o  = en_q[PORT_WEST];
  assign east_enable_o  = en_q[PORT_EAST];

endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed bench for router_input_arbiter.
// Enable vectors are checked as {north, south, west, east}.
module tb_router_input_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] n_d, s_d, w_d, e_d;
  logic        n_en, s_en, w_en, e_en;
  logic        n_rdy, s_rdy, w_rdy, e_rdy;
  logic        stall;
  logic [15:0] dout;
  logic        n_o, s_o, w_o, e_o;

  int total = 0;
  int bad   = 0;

  router_input_arbiter #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .north_data_i   (n_d),
    .north_enable_i (n_en),
    .north_ready_o  (n_rdy),
    .south_data_i   (s_d),
    .south_enable_i (s_en),
    .south_ready_o  (s_rdy),
    .west_data_i    (w_d),
    .west_enable_i  (w_en),
    .west_ready_o   (w_rdy),
    .east_data_i    (e_d),
    .east_enable_i  (e_en),
    .east_ready_o   (e_rdy),
    .stall_i        (stall),
    .data_o         (dout),
    .north_enable_o (n_o),
    .south_enable_o (s_o),
    .west_enable_o  (w_o),
    .east_enable_o  (e_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d,
                         input logic [3:0] en);
    chk({tag, ".data"}, 32'(dout), 32'(d));
    chk({tag, ".en"}, 32'({n_o, s_o, w_o, e_o}), 32'(en));
  endtask

  task automatic idle_in;
    n_en = 0; s_en = 0; w_en = 0; e_en = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    idle_in();
    stall = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  logic [15:0] exp_d [4];
  logic [3:0]  exp_e [4];

  initial begin
    rst_n = 0; stall = 0;
    n_d = 16'h00F1; s_d = 16'h00F2; w_d = 16'h00F3; e_d = 16'h00F4;
    n_en = 1; s_en = 1; w_en = 1; e_en = 1;

    // Reset held with all enables high
    tick();
    tick();
    chk_out("rst", 16'h0, 4'b0000);
    chk("rst.rdy", 32'({n_rdy, s_rdy, w_rdy, e_rdy}), 32'hF);
    rst_n = 1;
    idle_in();
    tick();
    chk_out("rst.post", 16'h0, 4'b0000);
    tick();
    chk_out("rst.post2", 16'h0, 4'b0000);
    chk("rst.rdy2", 32'({n_rdy, s_rdy, w_rdy, e_rdy}), 32'hF);

    // Single north word
    n_d = 16'h00A1; n_en = 1;
    tick();
    n_en = 0;
    chk_out("single.push", 16'h0, 4'b0000);
    tick();
    chk_out("single.out", 16'h00A1, 4'b1000);
    tick();
    chk_out("single.idle", 16'h0, 4'b0000);

    // All four ports push together
    do_reset();
    n_d = 16'h0001; s_d = 16'h0002; w_d = 16'h0003; e_d = 16'h0004;
    n_en = 1; s_en = 1; w_en = 1; e_en = 1;
    tick();
    idle_in();
    tick();
    chk_out("rr0", 16'h0001, 4'b1000);
    tick();
    chk_out("rr1", 16'h0002, 4'b0100);
    tick();
    chk_out("rr2", 16'h0003, 4'b0010);
    tick();
    chk_out("rr3", 16'h0004, 4'b0001);
    tick();
    chk_out("rr.idle", 16'h0, 4'b0000);

    // West fills under stall, fifth word dropped
    do_reset();
    stall = 1;
    w_en = 1;
    for (int k = 0; k < 5; k++) begin
      w_d = 16'h0010 + 16'(k);
      tick();
      chk_out($sformatf("full.stall%0d", k), 16'h0, 4'b0000);
      chk($sformatf("full.rdy%0d", k), 32'(w_rdy), (k < 3) ? 32'd1 : 32'd0);
    end
    w_en = 0;
    stall = 0;
    tick();
    chk_out("full.out0", 16'h0010, 4'b0010);
    chk("full.rdy.back", 32'(w_rdy), 32'd1);
    tick();
    chk_out("full.out1", 16'h0011, 4'b0010);
    tick();
    chk_out("full.out2", 16'h0012, 4'b0010);
    tick();
    chk_out("full.out3", 16'h0013, 4'b0010);
    tick();
    chk_out("full.idle", 16'h0, 4'b0000);

    // North and east two words each, released after stall
    do_reset();
    stall = 1;
    n_en = 1; e_en = 1;
    n_d = 16'h0101; e_d = 16'h0E01;
    tick();
    n_d = 16'h0102; e_d = 16'h0E02;
    tick();
    idle_in();
    stall = 0;
`ifdef ARB_FIXED_PRIORITY_EN
    exp_d = '{16'h0101, 16'h0102, 16'h0E01, 16'h0E02};
    exp_e = '{4'b1000, 4'b1000, 4'b0001, 4'b0001};
`else
    exp_d = '{16'h0101, 16'h0E01, 16'h0102, 16'h0E02};
    exp_e = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("prio%0d", k), exp_d[k], exp_e[k]);
    end
    tick();
    chk_out("prio.idle", 16'h0, 4'b0000);

    // Stall mid-stream: output drops to idle, then resumes in order
    do_reset();
    s_en = 1; s_d = 16'h0201;
    tick();
    s_d = 16'h0202;
    tick();
    chk_out("stallmid.0", 16'h0201, 4'b0100);
    idle_in();
    stall = 1;
    tick();
    chk_out("stallmid.hold", 16'h0, 4'b0000);
    stall = 0;
    tick();
    chk_out("stallmid.1", 16'h0202, 4'b0100);

    // Reset discards buffered south words
    do_reset();
    stall = 1;
    s_en = 1;
    for (int k = 0; k < 3; k++) begin
      s_d = 16'h0030 + 16'(k);
      tick();
    end
    idle_in();
    stall = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk_out("midrst", 16'h0, 4'b0000);
    chk("midrst.rdy", 32'(s_rdy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("midrst.after%0d", k), 16'h0, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
